operand_entry_ctrl: RTL and testbench
=====================================

OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 Parameter SHALL be: NIBBLES, 4, nibbles per operand (fixed at 4 for 16-bit operands).
REQ-002 Port SHALL be: clk  in  1  system clock; all state updates on rising edge.
REQ-003 Port SHALL be: rst  in  1  reset; synchronous and active-high.
REQ-004 Port SHALL be: load_btn  in  1  debounced, synchronized load button level.
REQ-005 Port SHALL be: clr_btn  in  1  debounced, synchronized clear level.
REQ-006 Port SHALL be: nib_in  in  4  nibble from switches, sampled on accepted load.
REQ-007 Port SHALL be: ops_ack  in  1  downstream consumed operands.
REQ-008 Port SHALL be: op_a  out  16  committed operand A.
REQ-009 Port SHALL be: op_b  out  16  committed operand B.
REQ-010 Port SHALL be: entry  out  16  partial value of operand being entered, for display.
REQ-011 Port SHALL be: nib_idx  out  2  nibbles already entered in current operand (0-3).
REQ-012 Port SHALL be: sel_b  out  1  high while entering operand B.
REQ-013 Port SHALL be: ops_valid  out  1  both operands committed and awaiting ack.

Function
REQ-014 Accepted load SHALL be: load_btn=1 at an edge where registered load_q=0; a held button yields exactly one load.
REQ-015 load_q SHALL register load_btn every cycle in every state, including READY and during clr_btn.
REQ-016 FSM states SHALL be ENTER_A, ENTER_B, READY.
REQ-017 In ENTER_A/ENTER_B on accepted load with nib_idx<3: entry <= {entry[11:0], nib_in}, nib_idx+1, same edge (zero-cycle latency).
REQ-018 On accepted load with nib_idx==3: target operand <= {entry[11:0], nib_in}; entry <= 0; nib_idx <= 0; ENTER_A->ENTER_B, ENTER_B->READY.
REQ-019 op_a SHALL hold stable throughout ENTER_B and READY; op_b stable in READY.
REQ-020 sel_b SHALL be 1 exactly in ENTER_B; ops_valid SHALL be 1 exactly in READY (registered, asserted the edge after the 8th load).
REQ-021 In READY, accepted loads SHALL be ignored (entry, nib_idx unchanged).
REQ-022 In READY with ops_ack=1: ops_valid <= 0, state <= ENTER_A; op_a/op_b retained until overwritten.
REQ-023 ops_ack outside READY SHALL have no effect.
REQ-024 ops_ack and accepted load on same edge in READY: ack applies, load discarded (not applied to new A).
REQ-025 clr_btn=1 at an edge: state ENTER_A, entry/nib_idx/op_a/op_b/ops_valid <= 0; priority clr over load and ack.
REQ-026 Priority order SHALL be rst > clr_btn > ops_ack > load.
REQ-027 Entry values SHALL be unsigned concatenation only; no arithmetic, no overflow possible.

Reset
REQ-028 rst=1 at an edge: state ENTER_A, all outputs 0, load_q <= 1 (button held across reset SHALL NOT count as a load).
REQ-029 Reset mid-entry or in READY SHALL discard partial and committed operands with no ack required.

Structure
REQ-030 Shared package SHALL hold NIBBLES, the FSM state enum (ENTER_A=0, ENTER_B=1, READY=2), and operand width 16.
REQ-031 One sub-module, btn_edge (registered rising-edge pulse, reset value 1), SHALL implement REQ-014/015/028.

Verification
REQ-032 Loads 1,2,3,4 then 5,6,7,8 -> op_a=16'h1234, op_b=16'h5678, ops_valid=1 the edge after the 8th load.
REQ-033 load_btn held high 20 cycles with nib_in=4'hA -> nib_idx increments once, entry=16'h000A.
REQ-034 READY, ops_ack and load edge on same cycle -> ops_valid=0, ENTER_A, nib_idx=0, entry=0.
REQ-035 Three loads of A, then clr_btn -> entry=0, nib_idx=0, op_a=0, sel_b=0.
REQ-036 load_btn held high while rst asserted then released with button still high -> no load counted until button released and pressed.
REQ-037 ops_ack pulsed during ENTER_B with nib_idx=2 -> no state or output change.

Source files
------------

// File: rtl/operand_entry_ctrl_pkg.sv
// Shared definitions for the operand entry controller: operand geometry and FSM state encoding.
package operand_entry_ctrl_pkg;

  localparam int NIBBLES = 4;
  localparam int OP_W    = 16;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    READY   = 2'd2
  } state_t;

endpackage

// File: rtl/operand_entry_ctrl_btn_edge.sv
// Rising-edge detector for a synchronized button level.
// The history register resets to 1 so a button held through reset does not produce a pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_q <= 1'b1;
    end else begin
      r_btn_q <= i_btn;
    end
  end

  assign o_pulse = i_btn & ~r_btn_q;

endmodule

// File: rtl/operand_entry_ctrl.sv
// Nibble-by-nibble entry of two 16-bit operands from switches and a load button,
// handing both to a downstream consumer and waiting for its acknowledge.
module operand_entry_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_btn,
  input  logic                   clr_btn,
  input  logic [3:0]             nib_in,
  input  logic                   ops_ack,
  output logic [4*NIBBLES-1:0]   op_a,
  output logic [4*NIBBLES-1:0]   op_b,
  output logic [4*NIBBLES-1:0]   entry,
  output logic [1:0]             nib_idx,
  output logic                   sel_b,
  output logic                   ops_valid
);

  import operand_entry_ctrl_pkg::*;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_load;
  logic              w_last_nib;
  logic [OP_W-1:0]   w_shifted;
  logic [OP_W-1:0]   r_entry;
  logic [OP_W-1:0]   r_op_a;
  logic [OP_W-1:0]   r_op_b;
  logic [1:0]        r_nib_idx;

  btn_edge u_load_edge (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (load_btn),
    .o_pulse (w_load)
  );

  assign w_last_nib = (r_nib_idx == 2'(NIBBLES - 1));
  assign w_shifted  = {r_entry[OP_W-5:0], nib_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ENTER_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Clear beats ack, and ack beats load, so READY + ack ignores a coincident load.
  always_comb begin
    w_next_state = r_state;
    if (clr_btn) begin
      w_next_state = ENTER_A;
    end else begin
      case (r_state)
        ENTER_A: if (w_load && w_last_nib) w_next_state = ENTER_B;
        ENTER_B: if (w_load && w_last_nib) w_next_state = READY;
        READY:   if (ops_ack)              w_next_state = ENTER_A;
        default: w_next_state = ENTER_A;
      endcase
    end
  end

  always_comb begin
    sel_b     = 1'b0;
    ops_valid = 1'b0;
    case (r_state)
      ENTER_B: sel_b     = 1'b1;
      READY:   ops_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr_btn) begin
      r_entry   <= '0;
      r_nib_idx <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
    end else if (w_load && (r_state == ENTER_A || r_state == ENTER_B)) begin
      if (w_last_nib) begin
        if (r_state == ENTER_A) begin
          r_op_a <= w_shifted;
        end else begin
          r_op_b <= w_shifted;
        end
        r_entry   <= '0;
        r_nib_idx <= '0;
      end else begin
        r_entry   <= w_shifted;
        r_nib_idx <= r_nib_idx + 2'd1;
      end
    end
  end

  assign op_a    = r_op_a;
  assign op_b    = r_op_b;
  assign entry   = r_entry;
  assign nib_idx = r_nib_idx;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed self-checking bench for operand_entry_ctrl with hand-computed expectations.
module tb_operand_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_btn;
  logic        clr_btn;
  logic [3:0]  nib_in;
  logic        ops_ack;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] entry;
  logic [1:0]  nib_idx;
  logic        sel_b;
  logic        ops_valid;

  int compared   = 0;
  int mismatched = 0;

  operand_entry_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_btn  (load_btn),
    .clr_btn   (clr_btn),
    .nib_in    (nib_in),
    .ops_ack   (ops_ack),
    .op_a      (op_a),
    .op_b      (op_b),
    .entry     (entry),
    .nib_idx   (nib_idx),
    .sel_b     (sel_b),
    .ops_valid (ops_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One press: button high for one edge, then low for one edge so the next press is a new edge.
  task automatic applyStimulus(input logic [3:0] nib);
    nib_in   = nib;
    load_btn = 1'b1;
    tick();
    load_btn = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; load_btn = 1'b0; clr_btn = 1'b0; nib_in = 4'h0; ops_ack = 1'b0;
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    checkOutput("rst_op_a",      op_a,      32'h0);
    checkOutput("rst_op_b",      op_b,      32'h0);
    checkOutput("rst_entry",     entry,     32'h0);
    checkOutput("rst_nib_idx",   nib_idx,   32'h0);
    checkOutput("rst_sel_b",     sel_b,     32'h0);
    checkOutput("rst_ops_valid", ops_valid, 32'h0);

    applyStimulus(4'h1);
    checkOutput("a1_entry",   entry,   32'h0001);
    checkOutput("a1_nib_idx", nib_idx, 32'h1);
    applyStimulus(4'h2);
    applyStimulus(4'h3);
    checkOutput("a3_entry",   entry,   32'h0123);
    checkOutput("a3_nib_idx", nib_idx, 32'h3);
    applyStimulus(4'h4);
    checkOutput("a4_op_a",    op_a,    32'h1234);
    checkOutput("a4_entry",   entry,   32'h0);
    checkOutput("a4_nib_idx", nib_idx, 32'h0);
    checkOutput("a4_sel_b",   sel_b,   32'h1);

    applyStimulus(4'h5);
    applyStimulus(4'h6);
    ops_ack = 1'b1;
    tick();
    ops_ack = 1'b0;
    checkOutput("ackB_nib_idx",   nib_idx,   32'h2);
    checkOutput("ackB_entry",     entry,     32'h0056);
    checkOutput("ackB_sel_b",     sel_b,     32'h1);
    checkOutput("ackB_ops_valid", ops_valid, 32'h0);
    checkOutput("ackB_op_a",      op_a,      32'h1234);

    applyStimulus(4'h7);
    nib_in   = 4'h8;
    load_btn = 1'b1;
    tick();
    checkOutput("b4_ops_valid", ops_valid, 32'h1);
    checkOutput("b4_op_b",      op_b,      32'h5678);
    checkOutput("b4_op_a",      op_a,      32'h1234);
    checkOutput("b4_sel_b",     sel_b,     32'h0);
    load_btn = 1'b0;
    tick();

    applyStimulus(4'h9);
    checkOutput("rdy_load_entry",   entry,     32'h0);
    checkOutput("rdy_load_nib_idx", nib_idx,   32'h0);
    checkOutput("rdy_load_valid",   ops_valid, 32'h1);

    nib_in   = 4'hF;
    load_btn = 1'b1;
    ops_ack  = 1'b1;
    tick();
    load_btn = 1'b0;
    ops_ack  = 1'b0;
    checkOutput("ackld_ops_valid", ops_valid, 32'h0);
    checkOutput("ackld_sel_b",     sel_b,     32'h0);
    checkOutput("ackld_nib_idx",   nib_idx,   32'h0);
    checkOutput("ackld_entry",     entry,     32'h0);
    checkOutput("ackld_op_a",      op_a,      32'h1234);
    checkOutput("ackld_op_b",      op_b,      32'h5678);
    tick();

    nib_in   = 4'hA;
    load_btn = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checkOutput("held_nib_idx", nib_idx, 32'h1);
    checkOutput("held_entry",   entry,   32'h000A);
    load_btn = 1'b0;
    tick();

    applyStimulus(4'hB);
    applyStimulus(4'hC);
    checkOutput("preclr_entry", entry, 32'h0ABC);
    clr_btn  = 1'b1;
    nib_in   = 4'hD;
    load_btn = 1'b1;
    tick();
    clr_btn  = 1'b0;
    load_btn = 1'b0;
    checkOutput("clr_entry",     entry,     32'h0);
    checkOutput("clr_nib_idx",   nib_idx,   32'h0);
    checkOutput("clr_op_a",      op_a,      32'h0);
    checkOutput("clr_op_b",      op_b,      32'h0);
    checkOutput("clr_sel_b",     sel_b,     32'h0);
    checkOutput("clr_ops_valid", ops_valid, 32'h0);
    tick();

    applyStimulus(4'h1);
    checkOutput("prerst_nib_idx", nib_idx, 32'h1);
    nib_in   = 4'h3;
    load_btn = 1'b1;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("rsthold_nib_idx", nib_idx, 32'h0);
    checkOutput("rsthold_entry",   entry,   32'h0);
    load_btn = 1'b0;
    tick();
    applyStimulus(4'h7);
    checkOutput("postrst_nib_idx", nib_idx, 32'h1);
    checkOutput("postrst_entry",   entry,   32'h0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
